// File: rtl/prog_loader_if.sv
// Byte-stream and instruction-memory write port bundle for the program loader.
// The master modport is the side that sources bytes and sinks memory writes.
interface prog_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_din;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, mem_we, mem_addr, mem_din
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/prog_loader.sv
// Framed byte-stream loader: length, big-endian payload words, XOR checksum.
// Writes each word to instruction memory and holds the CPU in reset until a good frame lands.
module prog_loader #(
  parameter int MAX_WORDS = 64
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  prog_loader_if.slave bus,
  output logic       o_cpu_rst,
  output logic       o_busy,
  output logic       o_err,
  output logic [6:0] o_words_loaded
);

  typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, RUN, ERR} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_rxReady;
  logic        r_busy;
  logic        r_err;
  logic        r_cpuRst;
  logic        r_memWe;
  logic [7:0]  r_memAddr;
  logic [31:0] r_memDin;
  logic [23:0] r_word;
  logic [1:0]  r_byteCnt;
  logic [5:0]  r_wordIndex;
  logic [6:0]  r_len;
  logic [6:0]  r_wordsLoaded;
  logic [7:0]  r_csum;

  logic w_accept;
  logic w_lastWord;
  logic w_lenBad;

  assign w_accept   = bus.rx_valid && r_rxReady;
  assign w_lastWord = (r_byteCnt == 2'd3) && (({1'b0, r_wordIndex} + 7'd1) == r_len);
  assign w_lenBad   = (bus.rx_data == 8'd0) || (bus.rx_data > 8'(MAX_WORDS));

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (i_start) w_next = LEN;
      LEN:      if (w_accept) w_next = w_lenBad ? ERR : DATA;
      DATA:     if (w_accept && w_lastWord) w_next = CSUM;
      CSUM:     if (w_accept) w_next = ((r_csum ^ bus.rx_data) == 8'd0) ? RUN : ERR;
      RUN, ERR: if (i_start) w_next = LEN;
      default:  w_next = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they track r_state exactly.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= IDLE;
      r_rxReady     <= 1'b0;
      r_busy        <= 1'b0;
      r_err         <= 1'b0;
      r_cpuRst      <= 1'b1;
      r_memWe       <= 1'b0;
      r_memAddr     <= 8'd0;
      r_memDin      <= 32'd0;
      r_word        <= 24'd0;
      r_byteCnt     <= 2'd0;
      r_wordIndex   <= 6'd0;
      r_len         <= 7'd0;
      r_wordsLoaded <= 7'd0;
      r_csum        <= 8'd0;
    end else begin
      r_state   <= w_next;
      r_rxReady <= (w_next == LEN) || (w_next == DATA) || (w_next == CSUM);
      r_busy    <= (w_next == LEN) || (w_next == DATA) || (w_next == CSUM);
      r_err     <= (w_next == ERR);
      r_cpuRst  <= (w_next != RUN);
      r_memWe   <= 1'b0;

      if ((w_next == LEN) && (r_state != LEN)) begin
        r_wordsLoaded <= 7'd0;
        r_byteCnt     <= 2'd0;
      end

      if (w_accept) begin
        case (r_state)
          LEN: begin
            r_len       <= bus.rx_data[6:0];
            r_csum      <= bus.rx_data;
            r_wordIndex <= 6'd0;
            r_byteCnt   <= 2'd0;
          end
          DATA: begin
            r_csum    <= r_csum ^ bus.rx_data;
            r_word    <= {r_word[15:0], bus.rx_data};
            r_byteCnt <= r_byteCnt + 2'd1;
            // Fourth byte completes the word: launch the write on this same edge.
            if (r_byteCnt == 2'd3) begin
              r_memWe       <= 1'b1;
              r_memDin      <= {r_word, bus.rx_data};
              r_memAddr     <= {r_wordIndex, 2'b00};
              r_wordIndex   <= r_wordIndex + 6'd1;
              r_wordsLoaded <= r_wordsLoaded + 7'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.rx_ready   = r_rxReady;
  assign bus.mem_we     = r_memWe;
  assign bus.mem_addr   = r_memAddr;
  assign bus.mem_din    = r_memDin;
  assign o_cpu_rst      = r_cpuRst;
  assign o_busy         = r_busy;
  assign o_err          = r_err;
  assign o_words_loaded = r_wordsLoaded;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized scoreboard bench for prog_loader: stimulus pushes expected writes,
// an independent monitor pops and compares them whenever mem_we is seen.
module tb_prog_loader;
  logic       clk;
  logic       rst;
  logic       start;
  logic       cpuRst;
  logic       busy;
  logic       err;
  logic [6:0] wordsLoaded;

  int total = 0;
  int bad   = 0;

  logic [39:0] expQ[$];
  logic [7:0]  frameBytes[$];

  prog_loader_if bus();

  prog_loader #(.MAX_WORDS(64)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_start        (start),
    .bus            (bus),
    .o_cpu_rst      (cpuRst),
    .o_busy         (busy),
    .o_err          (err),
    .o_words_loaded (wordsLoaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: every write pulse must match the oldest outstanding expectation.
  initial begin
    logic [39:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (bus.mem_we === 1'b1) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_we", {24'd0, bus.mem_addr}, 32'hFFFF_FFFF);
        end else begin
          e = expQ.pop_front();
          checkOutput("mem_addr", {24'd0, bus.mem_addr}, {24'd0, e[39:32]});
          checkOutput("mem_din", bus.mem_din, e[31:0]);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Caller invariant: every task is entered and left just after a falling edge.
  task automatic sendByte(input logic [7:0] b, input bit gaps);
    int budget;
    if (gaps) begin
      while ($urandom_range(0, 2) == 0) begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
        @(negedge clk);
      end
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    budget = 0;
    while (bus.rx_ready !== 1'b1 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 50) begin
      checkOutput("rx_ready_timeout", 32'd0, 32'd1);
    end else begin
      @(negedge clk);
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_rx_ready"}, {31'd0, bus.rx_ready}, 32'd0);
    checkOutput({tag, "_mem_we"}, {31'd0, bus.mem_we}, 32'd0);
    checkOutput({tag, "_mem_addr"}, {24'd0, bus.mem_addr}, 32'd0);
    checkOutput({tag, "_mem_din"}, bus.mem_din, 32'd0);
    checkOutput({tag, "_cpu_rst"}, {31'd0, cpuRst}, 32'd1);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_err"}, {31'd0, err}, 32'd0);
    checkOutput({tag, "_words"}, {25'd0, wordsLoaded}, 32'd0);
  endtask

  task automatic doStart(input bit withValid);
    start = 1'b1;
    if (withValid) begin
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'hFF;
    end
    @(negedge clk);
    start        = 1'b0;
    bus.rx_valid = 1'b0;
    checkOutput("start_busy", {31'd0, busy}, 32'd1);
    checkOutput("start_cpu_rst", {31'd0, cpuRst}, 32'd1);
    checkOutput("start_err", {31'd0, err}, 32'd0);
    checkOutput("start_words", {25'd0, wordsLoaded}, 32'd0);
    checkOutput("start_rx_ready", {31'd0, bus.rx_ready}, 32'd1);
  endtask

  task automatic fillRandom(input int nWords);
    frameBytes.delete();
    for (int i = 0; i < nWords * 4; i++) frameBytes.push_back(8'($urandom));
  endtask

  // Sends one frame from frameBytes; abortAfter >= 0 pulls reset after that many payload bytes.
  task automatic applyStimulus(input bit badCsum, input bit gaps, input int abortAfter, input bit withValid);
    int          n;
    logic [7:0]  csum;
    logic [7:0]  nByte;
    logic [31:0] w;
    n     = frameBytes.size() / 4;
    nByte = 8'(n);
    doStart(withValid);
    sendByte(nByte, gaps);
    csum = nByte;
    for (int i = 0; i < n * 4; i++) begin
      if (i == abortAfter) begin
        rst = 1'b1;
        #1;
        checkResetValues("midreset");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("midreset_pending", expQ.size(), 32'd0);
        return;
      end
      csum ^= frameBytes[i];
      if (i % 4 == 3) begin
        w = {frameBytes[i-3], frameBytes[i-2], frameBytes[i-1], frameBytes[i]};
        expQ.push_back({8'((i / 4) * 4), w});
      end
      sendByte(frameBytes[i], gaps);
    end
    checkOutput("pre_csum_cpu_rst", {31'd0, cpuRst}, 32'd1);
    checkOutput("pre_csum_busy", {31'd0, busy}, 32'd1);
    checkOutput("pre_csum_words", {25'd0, wordsLoaded}, 32'(n));
    sendByte(badCsum ? (csum ^ 8'h01) : csum, gaps);
    checkOutput("post_cpu_rst", {31'd0, cpuRst}, {31'd0, badCsum});
    checkOutput("post_err", {31'd0, err}, {31'd0, badCsum});
    checkOutput("post_busy", {31'd0, busy}, 32'd0);
    checkOutput("post_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
    checkOutput("post_words", {25'd0, wordsLoaded}, 32'(n));
    repeat (2) @(negedge clk);
    checkOutput("pending_writes", expQ.size(), 32'd0);
  endtask

  task automatic badLength(input logic [7:0] len);
    doStart(1'b0);
    sendByte(len, 1'b0);
    checkOutput("badlen_err", {31'd0, err}, 32'd1);
    checkOutput("badlen_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
    checkOutput("badlen_cpu_rst", {31'd0, cpuRst}, 32'd1);
    checkOutput("badlen_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("badlen_err_hold", {31'd0, err}, 32'd1);
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    checkResetValues("reset");
    rst = 1'b0;
    @(negedge clk);

    frameBytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    applyStimulus(1'b0, 1'b0, -1, 1'b1);
    applyStimulus(1'b1, 1'b0, -1, 1'b0);

    badLength(8'h00);
    badLength(8'h41);

    fillRandom(64);
    applyStimulus(1'b0, 1'b1, -1, 1'b0);

    fillRandom(3);
    applyStimulus(1'b0, 1'b0, -1, 1'b0);

    fillRandom(4);
    applyStimulus(1'b0, 1'b0, 6, 1'b0);
    fillRandom(5);
    applyStimulus(1'b0, 1'b1, -1, 1'b0);

    for (int k = 0; k < 6; k++) begin
      fillRandom($urandom_range(1, 8));
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, 1'b0);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
